// File: rtl/mac_kbd_serial.sv
// mac_kbd_serial
//   Keyboard end of the Mac Plus keyboard serial link. The keyboard always
//   drives the clock (CB1); the Mac asks for a transfer by pulling the shared
//   data line (CB2) low. Received commands are handed to the key translator as
//   byte + strobe, and the translator's reply byte is clocked back to the Mac.
//
// Ports
//   clk, reset    system clock, asynchronous active-high reset
//   ce            timing enable; all state advances only when ce=1
//   mac_data      Mac's CB2 drive value (1 = released)
//   kbd_data      keyboard's CB2 drive value (1 = released)
//   kbd_clk       CB1 clock to the VIA
//   cmd_data      last received command byte
//   cmd_strobe    one-ce-period pulse, cmd_data valid
//   reply_data    reply byte from translator
//   reply_strobe  reply valid (sampled on ce)
//   busy          not idle
//   overrun       sticky: a reply arrived while one was still pending
module mac_kbd_serial #(
  parameter int unsigned T_REQ     = 8,
  parameter int unsigned T_RX_LOW  = 180,
  parameter int unsigned T_RX_HIGH = 220,
  parameter int unsigned T_TX_LOW  = 160,
  parameter int unsigned T_TX_HIGH = 170,
  parameter int unsigned T_GUARD   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       mac_data,
  output logic       kbd_data,
  output logic       kbd_clk,
  output logic [7:0] cmd_data,
  output logic       cmd_strobe,
  input  logic [7:0] reply_data,
  input  logic       reply_strobe,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT, S_TX, S_GUARD} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;    // phase timer; also request debounce in IDLE/WAIT
  logic [2:0]  bit_q, bit_d;
  logic        hi_q, hi_d;      // 1 = high half of the current bit
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rep_q, rep_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        stb_q, stb_d;
  logic        clk_q, clk_d;
  logic        dat_q, dat_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      sh_q    <= '0;
      rep_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cmd_q   <= '0;
      stb_q   <= 1'b0;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      rep_q   <= rep_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      cmd_q   <= cmd_d;
      stb_q   <= stb_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    rep_d   = rep_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    cmd_d   = cmd_q;
    stb_d   = stb_q;
    clk_d   = clk_q;
    dat_d   = dat_q;

    if (ce) begin
      stb_d = 1'b0;

      // Reply latch runs in every state; the state logic below may clear
      // pending afterwards (new request, or transmission start).
      if (reply_strobe) begin
        if (pend_q) begin
          ovr_d = 1'b1;
        end else begin
          pend_d = 1'b1;
          rep_d  = reply_data;
        end
      end

      case (state_q)
        S_IDLE, S_WAIT: begin
          clk_d = 1'b1;
          dat_d = 1'b1;
          if (state_q == S_WAIT && pend_q) begin
            // start TX: first bit goes out with the falling clock
            state_d = S_TX;
            cnt_d   = '0;
            bit_d   = '0;
            hi_d    = 1'b0;
            clk_d   = 1'b0;
            dat_d   = rep_q[7];
            sh_d    = {rep_q[6:0], 1'b0};
            pend_d  = 1'b0;
          end else if (!mac_data) begin
            if (cnt_q == 10'(T_REQ - 1)) begin
              state_d = S_RX;
              cnt_d   = '0;
              bit_d   = '0;
              hi_d    = 1'b0;
              clk_d   = 1'b0;
              pend_d  = 1'b0;   // a new command supersedes an unsent reply
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end else begin
            cnt_d = '0;
            if (state_q == S_IDLE && pend_q) begin
              state_d = S_TX;
              cnt_d   = '0;
              bit_d   = '0;
              hi_d    = 1'b0;
              clk_d   = 1'b0;
              dat_d   = rep_q[7];
              sh_d    = {rep_q[6:0], 1'b0};
              pend_d  = 1'b0;
            end
          end
        end

        S_RX: begin
          if (!hi_q) begin
            if (cnt_q == 10'(T_RX_LOW - 1)) begin
              clk_d = 1'b1;
              hi_d  = 1'b1;
              cnt_d = '0;
              sh_d  = {sh_q[6:0], mac_data};
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end else if (cnt_q == 10'(T_RX_HIGH - 1)) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              cmd_d   = sh_q;
              stb_d   = 1'b1;
              state_d = S_WAIT;
            end else begin
              clk_d = 1'b0;
              hi_d  = 1'b0;
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        S_TX: begin
          if (!hi_q) begin
            if (cnt_q == 10'(T_TX_LOW - 1)) begin
              clk_d = 1'b1;
              hi_d  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end else if (cnt_q == 10'(T_TX_HIGH - 1)) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              dat_d   = 1'b1;
              state_d = S_GUARD;
            end else begin
              clk_d = 1'b0;
              hi_d  = 1'b0;
              dat_d = sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        S_GUARD: begin
          clk_d = 1'b1;
          dat_d = 1'b1;
          if (cnt_q == 10'(T_GUARD - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b1;
          dat_d   = 1'b1;
        end
      endcase
    end
  end

  assign kbd_clk    = clk_q;
  assign kbd_data   = dat_q;
  assign cmd_data   = cmd_q;
  assign cmd_strobe = stb_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = ovr_q;

endmodule
